ldpc_rd_sched: RTL

LDPC_RD_SCHED -- requirements
Module: ldpc_rd_sched

---
 rtl/ldpc_rd_sched.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ldpc_rd_sched.sv
// ldpc_rd_sched: LDPC decode read-address scheduler (3 sub-cycles per row, rows per iteration, then output phase)
module ldpc_rd_sched #(
  parameter int A_WID = 8,
  parameter int R_WID = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stall,
  input  logic [R_WID-1:0] num_rows,
  input  logic [R_WID-1:0] num_iters,
  input  logic [A_WID-1:0] base_start,
  input  logic [A_WID-1:0] base_stride,
  input  logic [A_WID-1:0] out_len,
  output logic             rd_en,
  output logic [1:0]       cycle,
  output logic [A_WID-1:0] base_addr,
  output logic [R_WID-1:0] row_idx,
  output logic [R_WID-1:0] iter_cnt,
  output logic             out_en,
  output logic [A_WID-1:0] out_addr,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, READ, OUT, DONE} state_t;
  state_t state, state_n;
  logic [1:0] cycle_n;
  logic [A_WID-1:0] base_n, oaddr_n, c_start, c_stride, c_olen;
  logic [R_WID-1:0] row_n, iter_n, c_rows, c_iters;
  logic rd_q, rd_n, out_q, out_n, lat;
  // Enables are held in registers; a stall blanks them in the cycle it is asserted while the held values stay put
  assign rd_en = rd_q & ~stall;
  assign out_en = out_q & ~stall;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // Next-state and next-value logic for the schedule
  always_comb begin
    state_n = state;
    cycle_n = cycle;
    base_n = base_addr;
    row_n = row_idx;
    iter_n = iter_cnt;
    oaddr_n = out_addr;
    rd_n = rd_q;
    out_n = out_q;
    lat = 1'b0;
    case (state)
      IDLE: if (start) begin
        lat = 1'b1;
        if (~|num_rows || ~|num_iters) begin
          state_n = ~|out_len ? DONE : OUT;
          out_n = |out_len;
          oaddr_n = '0;
        end else begin
          state_n = READ;
          rd_n = 1'b1;
          cycle_n = 2'd1;
          row_n = '0;
          iter_n = '0;
          base_n = base_start;
        end
      end
      READ: if (!stall) begin
        if (cycle != 2'd3) cycle_n = cycle + 2'd1;
        else if (row_idx != c_rows - 1'b1) begin
          cycle_n = 2'd1;
          row_n = row_idx + 1'b1;
          base_n = base_addr + c_stride;
        end else if (iter_cnt != c_iters - 1'b1) begin
          cycle_n = 2'd1;
          row_n = '0;
          base_n = c_start;
          iter_n = iter_cnt + 1'b1;
        end else begin
          state_n = ~|c_olen ? DONE : OUT;
          out_n = |c_olen;
          rd_n = 1'b0;
          cycle_n = 2'd0;
          row_n = '0;
          iter_n = '0;
          base_n = '0;
          oaddr_n = '0;
        end
      end
      OUT: if (!stall) begin
        if (out_addr == c_olen - 1'b1) begin
          state_n = DONE;
          out_n = 1'b0;
          oaddr_n = '0;
        end else oaddr_n = out_addr + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // State and schedule registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cycle <= '0;
      base_addr <= '0;
      row_idx <= '0;
      iter_cnt <= '0;
      out_addr <= '0;
      rd_q <= 1'b0;
      out_q <= 1'b0;
    end else begin
      state <= state_n;
      cycle <= cycle_n;
      base_addr <= base_n;
      row_idx <= row_n;
      iter_cnt <= iter_n;
      out_addr <= oaddr_n;
      rd_q <= rd_n;
      out_q <= out_n;
    end
  end
  // Configuration captured only when a start is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_rows <= '0;
      c_iters <= '0;
      c_start <= '0;
      c_stride <= '0;
      c_olen <= '0;
    end else if (lat) begin
      c_rows <= num_rows;
      c_iters <= num_iters;
      c_start <= base_start;
      c_stride <= base_stride;
      c_olen <= out_len;
    end
  end
endmodule
